// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-line engine.
package sd_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_136  = 2'b01;
  localparam logic [1:0] RSP_48   = 2'b10;
  localparam logic [1:0] RSP_48B  = 2'b11;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CRC     = 1;
  localparam int ERR_END     = 2;
  localparam int ERR_INDEX   = 3;

  localparam int LEN_48  = 48;
  localparam int LEN_136 = 136;
endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first input, cleared to zero.
module sd_crc7 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);
  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb = bit_in ^ r_crc[6];
  assign crc  = r_crc;

  always_ff @(posedge clock) begin
    if (reset || clear) r_crc <= '0;
    else if (enable)    r_crc <= {r_crc[5:0], 1'b0} ^ {3'b000, w_fb, 2'b00, w_fb};
  end
endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command frame with CRC7, then
// waits for, captures and checks the card response.
module sd_cmd_engine
  import sd_cmd_pkg::*;
#(
  parameter int NCR_TIMEOUT = 64,
  parameter int NCR_MIN     = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  command,
  input  logic [31:0]  argument,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         busy,
  output logic         command_complete,
  output logic [127:0] response_o,
  output logic [15:0]  error_interrupt_status_o,
  output logic [15:0]  normal_interrupt_status_o
);
  localparam int CNT_MAX = (NCR_MIN + NCR_TIMEOUT > LEN_136) ? NCR_MIN + NCR_TIMEOUT : LEN_136;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [47:0]    r_tx;
  logic [126:0]   r_rx;
  logic [5:0]     r_idx;
  logic           r_ichk, r_cchk;
  logic [1:0]     r_rtype;
  logic [3:0]     r_err, w_err_nxt;
  logic [15:0]    r_norm;
  logic [127:0]   r_resp;

  logic [127:0]   w_rx;
  logic           w_long;
  logic [CW-1:0]  w_len;
  logic [6:0]     w_crc;
  logic [2:0]     w_ci;
  logic           w_crc_clr, w_crc_en, w_crc_bit;
  logic           w_unused;

  assign w_unused = &{1'b0, command[15:14], command[7:5], command[2]};
  assign w_rx     = {r_rx, cmd_i};
  assign w_long   = (r_rtype == RSP_136);
  assign w_len    = w_long ? CW'(LEN_136) : CW'(LEN_48);
  assign w_ci     = 3'(6'd46 - 6'(r_cnt));

  sd_crc7 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_crc_clr),
    .enable (w_crc_en),
    .bit_in (w_crc_bit),
    .crc    (w_crc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_crc_clr   = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_bit   = r_tx[47];
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_SEND;
        w_err_nxt   = '0;
        w_crc_clr   = 1'b1;
      end
      S_SEND: begin
        w_crc_en = (r_cnt < CW'(40));
        if (r_cnt == CW'(47)) w_state_nxt = (r_rtype == RSP_NONE) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        // The start bit is zero, so clearing the CRC here also accounts for it.
        if (r_cnt >= CW'(NCR_MIN) && !cmd_i) begin
          w_state_nxt = S_RECV;
          w_crc_clr   = 1'b1;
        end else if (r_cnt == CW'(NCR_MIN + NCR_TIMEOUT - 1)) begin
          w_state_nxt            = S_DONE;
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
        end
      end
      S_RECV: begin
        w_crc_bit = cmd_i;
        w_crc_en  = (r_cnt < w_len - CW'(8)) && (!w_long || r_cnt >= CW'(8));
        if (r_cnt == w_len - CW'(1)) begin
          w_state_nxt = S_DONE;
          if (!cmd_i)                         w_err_nxt[ERR_END]   = 1'b1;
          if (r_cchk && (w_crc != w_rx[7:1])) w_err_nxt[ERR_CRC]   = 1'b1;
          if (!w_long && r_ichk && (w_rx[45:40] != r_idx)) w_err_nxt[ERR_INDEX] = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_idx   <= '0;
      r_ichk  <= 1'b0;
      r_cchk  <= 1'b0;
      r_rtype <= RSP_NONE;
      r_err   <= '0;
      r_norm  <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (r_state != w_state_nxt) r_cnt <= (w_state_nxt == S_RECV) ? CW'(1) : '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + CW'(1);

      if (r_state == S_IDLE && start) begin
        r_tx    <= {2'b01, command[13:8], argument, 7'b0, 1'b1};
        r_idx   <= command[13:8];
        r_ichk  <= command[4];
        r_cchk  <= command[3];
        r_rtype <= command[1:0];
        r_norm  <= '0;
      end
      if (r_state == S_SEND) r_tx <= {r_tx[46:0], 1'b0};
      if (r_state == S_WAIT && w_state_nxt == S_RECV) r_rx <= '0;
      if (r_state == S_RECV) begin
        r_rx <= w_rx[126:0];
        if (w_state_nxt == S_DONE)
          r_resp <= w_long ? {8'b0, w_rx[127:8]} : {96'b0, w_rx[39:8]};
      end
      if (w_state_nxt == S_DONE && r_state != S_DONE)
        r_norm <= {|w_err_nxt, 14'b0, ~|w_err_nxt};
    end
  end

  // CRC bits 7..1 come straight from the CRC register; the shifter carries zeros there.
  always_comb begin
    cmd_o = 1'b1;
    if (r_state == S_SEND) begin
      if (r_cnt < CW'(40))      cmd_o = r_tx[47];
      else if (r_cnt < CW'(47)) cmd_o = w_crc[w_ci];
    end
  end

  assign cmd_oe                    = (r_state == S_SEND);
  assign busy                      = (r_state != S_IDLE);
  assign command_complete          = (r_state == S_DONE);
  assign response_o                = r_resp;
  assign error_interrupt_status_o  = {12'b0, r_err};
  assign normal_interrupt_status_o = r_norm;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with a frame-level reference model.
module tb_sd_cmd_engine;
  localparam int NCR_TIMEOUT = 64;
  localparam int NCR_MIN     = 2;

  logic         clock = 1'b0, reset = 1'b1, start = 1'b0, cmd_i = 1'b1;
  logic [15:0]  command = '0;
  logic [31:0]  argument = '0;
  logic         cmd_o, cmd_oe, busy, command_complete;
  logic [127:0] response_o;
  logic [15:0]  error_interrupt_status_o, normal_interrupt_status_o;

  sd_cmd_engine #(.NCR_TIMEOUT(NCR_TIMEOUT), .NCR_MIN(NCR_MIN)) dut (
    .clock(clock), .reset(reset), .start(start), .command(command), .argument(argument),
    .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe), .busy(busy),
    .command_complete(command_complete), .response_o(response_o),
    .error_interrupt_status_o(error_interrupt_status_o),
    .normal_interrupt_status_o(normal_interrupt_status_o)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model state: what is on the bus and what the status registers must show.
  bit           mon = 1'b0, active = 1'b0;
  int           start_cyc = 0, m_done = 0, m_ts = -1, m_rlen = 0;
  logic [47:0]  m_frame = '0;
  logic [135:0] m_rx = '0;
  logic [15:0]  m_err = '0, m_norm = '0, f_err = '0, f_norm = '0;
  logic [127:0] m_resp = '0, f_resp = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // CRC7 as polynomial long division of d(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
    logic [134:0] v;
    v = {d, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] f;
    f = {2'b01, idx, arg};
    return {f, crc7(128'(f), 40), 1'b1};
  endfunction

  function automatic logic [135:0] reply48(input logic [5:0] idx, input logic [31:0] arg,
                                           input bit ovr, input logic [6:0] cv, input logic eb);
    logic [39:0] r;
    logic [6:0]  c;
    r = {2'b00, idx, arg};
    c = ovr ? cv : crc7(128'(r), 40);
    return 136'({r, c, eb});
  endfunction

  always @(negedge clock) begin : cmp
    int   t;
    logic e_oe, e_o, e_busy, e_cc;
    if (mon) begin
      t = cyc - start_cyc;
      if (active && t == 1) begin m_err = '0; m_norm = '0; end
      if (active && t == m_done) begin m_err = f_err; m_norm = f_norm; m_resp = f_resp; end
      e_oe   = active && t >= 1 && t <= 48;
      e_o    = 1'b1;
      if (e_oe) e_o = m_frame[48 - t];
      e_busy = active && t >= 1 && t <= m_done;
      e_cc   = active && t == m_done;
      check("cmd_oe", 128'(cmd_oe), 128'(e_oe));
      check("cmd_o", 128'(cmd_o), 128'(e_o));
      check("busy", 128'(busy), 128'(e_busy));
      check("command_complete", 128'(command_complete), 128'(e_cc));
      check("error_status", 128'(error_interrupt_status_o), 128'(m_err));
      check("normal_status", 128'(normal_interrupt_status_o), 128'(m_norm));
      check("response", response_o, m_resp);
    end
  end

  // Card side: drive the scheduled reply, otherwise keep the line high.
  always @(posedge clock) begin
    int t;
    #2;
    t = cyc - start_cyc;
    if (active && m_ts >= 0 && t >= m_ts && t < m_ts + m_rlen) cmd_i = m_rx[m_rlen - 1 - (t - m_ts)];
    else cmd_i = 1'b1;
  end

  task automatic run(input logic [5:0] idx, input bit ichk, input bit cchk, input logic [1:0] rt,
                     input logic [31:0] arg, input logic [135:0] rx, input int rlen, input int ts,
                     input bit glitch, input int rst_at);
    logic [15:0] e;
    logic [6:0]  c;
    @(posedge clock); #1;
    m_frame = frame(idx, arg);
    e = '0;
    f_resp = m_resp;
    if (rt == 2'b00) m_done = 49;
    else if (ts < 0) begin
      m_done = 49 + NCR_MIN + NCR_TIMEOUT;
      e[0] = 1'b1;
    end else begin
      m_done = ts + rlen;
      c = (rlen == 48) ? crc7(128'(rx[47:8]), 40) : crc7(128'(rx[127:8]), 120);
      if (!rx[0]) e[2] = 1'b1;
      if (cchk && c != rx[7:1]) e[1] = 1'b1;
      if (rlen == 48 && ichk && rx[45:40] != idx) e[3] = 1'b1;
      f_resp = (rlen == 48) ? {96'b0, rx[39:8]} : {8'b0, rx[127:8]};
    end
    f_err  = e;
    f_norm = (e == 0) ? 16'h0001 : 16'h8000;
    m_rx = rx; m_rlen = rlen; m_ts = ts;
    command  = {2'b00, idx, 3'b000, ichk, cchk, 1'b0, rt};
    argument = arg;
    start = 1'b1;
    start_cyc = cyc;
    active = 1'b1;
    for (int k = 1; k <= m_done + 3; k++) begin
      @(posedge clock); #1;
      start = glitch && k == 20;
      if (glitch && k == 20) begin command = 16'h3A1A; argument = 32'hDEADBEEF; end
      if (rst_at > 0 && k == rst_at) reset = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) begin
        reset = 1'b0; active = 1'b0;
        m_err = '0; m_norm = '0; m_resp = '0;
      end
    end
  endtask

  logic [135:0] rsp_ok;
  logic [119:0] payload;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_o", 128'(cmd_o), 128'(1'b1));
    check("rst_cmd_oe", 128'(cmd_oe), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_cc", 128'(command_complete), 128'(1'b0));
    check("rst_resp", response_o, 128'(0));
    check("rst_err", 128'(error_interrupt_status_o), 128'(0));
    check("rst_norm", 128'(normal_interrupt_status_o), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    mon = 1'b1;

    rsp_ok = reply48(6'd8, 32'h1AA, 1'b0, 7'd0, 1'b1);
    check("model_frame_cmd0", 128'(frame(6'd0, 32'h0)), 128'h400000000095);
    check("model_frame_cmd17", 128'(frame(6'd17, 32'h0)), 128'h510000000055);
    check("model_frame_cmd8", 128'(frame(6'd8, 32'h1AA)), 128'h48000001AA87);
    check("model_reply_cmd8", rsp_ok[127:0], 128'h08000001AA13);

    // CMD0, no response, with a stray start during SEND
    run(6'd0, 1'b0, 1'b0, 2'b00, 32'h0, '0, 0, -1, 1'b1, 0);
    check("cmd0_norm_lit", 128'(normal_interrupt_status_o), 128'h0001);
    // CMD17, 48-bit response never arrives
    run(6'd17, 1'b0, 1'b0, 2'b10, 32'h0, '0, 0, -1, 1'b0, 0);
    check("timeout_err_lit", 128'(error_interrupt_status_o), 128'h0001);
    check("timeout_norm_lit", 128'(normal_interrupt_status_o), 128'h8000);
    // CMD8 good reply after 5 idle cycles
    run(6'd8, 1'b1, 1'b1, 2'b10, 32'h1AA, rsp_ok, 48, 54, 1'b0, 0);
    check("cmd8_resp_lit", response_o, 128'h1AA);
    check("cmd8_err_lit", 128'(error_interrupt_status_o), 128'h0);
    // CRC byte 0x15
    run(6'd8, 1'b1, 1'b1, 2'b10, 32'h1AA, reply48(6'd8, 32'h1AA, 1'b1, 7'h0A, 1'b1), 48, 54, 1'b0, 0);
    check("crc_err_lit", 128'(error_interrupt_status_o), 128'h0002);
    // wrong index, consistent CRC
    run(6'd8, 1'b1, 1'b1, 2'b10, 32'h1AA, reply48(6'd9, 32'h1AA, 1'b0, 7'd0, 1'b1), 48, 55, 1'b0, 0);
    check("idx_err_lit", 128'(error_interrupt_status_o), 128'h0008);
    // end bit low
    run(6'd8, 1'b1, 1'b1, 2'b11, 32'h1AA, reply48(6'd8, 32'h1AA, 1'b0, 7'd0, 1'b0), 48, 51, 1'b0, 0);
    check("end_err_lit", 128'(error_interrupt_status_o), 128'h0004);
    // bad CRC ignored when CRC check disabled
    run(6'd8, 1'b0, 1'b0, 2'b10, 32'h1AA, reply48(6'd8, 32'h1AA, 1'b1, 7'h0A, 1'b1), 48, 60, 1'b0, 0);
    check("nocrc_err_lit", 128'(error_interrupt_status_o), 128'h0000);
    // 136-bit response
    payload = 120'h00112233445566778899AABBCCDDEE;
    run(6'd2, 1'b1, 1'b1, 2'b01, 32'h0, {8'h3F, payload, crc7(128'(payload), 120), 1'b1}, 136, 54, 1'b0, 0);
    check("r136_resp_lit", response_o, 128'h0000112233445566778899AABBCCDDEE);
    check("r136_err_lit", 128'(error_interrupt_status_o), 128'h0);
    // reset in the middle of SEND, then a clean command
    run(6'd0, 1'b0, 1'b0, 2'b00, 32'h0, '0, 0, -1, 1'b0, 10);
    check("abort_busy_lit", 128'(busy), 128'(1'b0));
    run(6'd0, 1'b0, 1'b0, 2'b00, 32'h12345678, '0, 0, -1, 1'b0, 0);
    check("after_abort_norm_lit", 128'(normal_interrupt_status_o), 128'h0001);

    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
